// File: rtl/reg7b_defs.sv
// Shared definitions for the 7-bit shared-register sequencer: FSM encodings and default sizes.
// Build option ARB_FIXED_PRIO_EN (see arbitro_rr) does not change anything in this package.
package reg7b_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam int REG7B_WIDTH = 7;
  localparam int REG7B_N_REQ = 4;

endpackage

// File: rtl/arbitro_rr.sv
// Combinational winner select: round-robin from ptr_i, or lowest-index-wins when
// ARB_FIXED_PRIO_EN is defined (ptr_i port is then absent). Zero latency, no backpressure.
module arbitro_rr #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
`ifndef ARB_FIXED_PRIO_EN
  input  logic [ID_W-1:0]  ptr_i,
`endif
  output logic [ID_W-1:0]  idx_o,
  output logic             vld_o
);

`ifdef ARB_FIXED_PRIO_EN

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    idx_o = '0;
    vld_o = |req_i;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = ID_W'(i);
    end
  end

`else

  localparam int CW = ID_W + 1;

  logic [CW-1:0] cand;

  // Offsets are scanned from far to near so the requester closest to the
  // pointer overwrites all others. Wrap uses an explicit compare so that
  // non-power-of-two N_REQ never lands on a nonexistent requester.
  always_comb begin
    idx_o = '0;
    vld_o = |req_i;
    cand  = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = {1'b0, ptr_i} + CW'(off);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (req_i[cand[ID_W-1:0]]) idx_o = cand[ID_W-1:0];
    end
  end

`endif

endmodule

// File: rtl/controlador_registrador7b.sv
// Shares one load-or-hold register among N_REQ requesters: IDLE -> LOAD (sinal=1) -> ACK (ack[w]=1).
// Grant at edge k gives sinal in cycle k+1 and ack in k+2; hold blocks new grants only in IDLE.
// Build option ARB_FIXED_PRIO_EN selects fixed priority and removes the round-robin pointer.
module controlador_registrador7b
  import reg7b_defs::*;
#(
  parameter int N_REQ = REG7B_N_REQ,
  parameter int WIDTH = REG7B_WIDTH,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] dados,
  input  logic                   hold,
  output logic [WIDTH-1:0]       d,
  output logic                   sinal,
  output logic [N_REQ-1:0]       ack,
  output logic [ID_W-1:0]        gnt_id,
  output logic                   busy
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  dat_q, dat_d;
  logic              sinal_q, sinal_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]   win_idx;
  logic              win_vld;
  logic [WIDTH-1:0]  lane [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      lane[i] = dados[i*WIDTH +: WIDTH];
    end
  end

`ifdef ARB_FIXED_PRIO_EN

  arbitro_rr #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i (req),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

`else

  logic [ID_W-1:0] ptr_q, ptr_d;

  arbitro_rr #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  // Pointer moves past the winner while acking, so a requester that keeps
  // req high is treated as a fresh request that ranks last.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_ACK) begin
      ptr_d = (gnt_q == ID_W'(N_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    sinal_d = 1'b0;
    ack_d   = '0;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!hold && win_vld) begin
          state_d = ST_LOAD;
          dat_d   = lane[win_idx];
          gnt_d   = win_idx;
          sinal_d = 1'b1;
        end
      end
      ST_LOAD: begin
        // Committed once LOAD is entered; req is not looked at again.
        state_d       = ST_ACK;
        ack_d[gnt_q]  = 1'b1;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dat_q   <= '0;
      sinal_q <= 1'b0;
      ack_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      sinal_q <= sinal_d;
      ack_q   <= ack_d;
      gnt_q   <= gnt_d;
    end
  end

  assign d      = dat_q;
  assign sinal  = sinal_q;
  assign ack    = ack_q;
  assign gnt_id = gnt_q;
  assign busy   = (state_q != ST_IDLE);

`ifndef SYNTHESIS
  a_load_ack_excl: assert property (@(posedge clk) disable iff (reset) !(sinal && (|ack)));
  a_ack_onehot0:   assert property (@(posedge clk) disable iff (reset) $onehot0(ack));
`endif

endmodule
